// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin EXU/LSU onto the single RF write
// port through a one-cycle output register, plus a per-register pending scoreboard.

module rf_wb_sb_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic busy
);
  always_ff @(posedge clk) begin
    if (!rst_n)   busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end
endmodule

module rf_wb_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [AWIDTH-1:0] alloc_rd,
  output logic              alloc_ready,
  input  logic [AWIDTH-1:0] raddr1,
  input  logic [AWIDTH-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  input  logic              exu_valid,
  input  logic [AWIDTH-1:0] exu_rd,
  input  logic [DWIDTH-1:0] exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [AWIDTH-1:0] lsu_rd,
  input  logic [DWIDTH-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic [AWIDTH:0]   pend_cnt,
  output logic              wb_err
);
  localparam int NREG = 1 << AWIDTH;

  typedef struct packed {
    logic [AWIDTH-1:0] rd;
    logic [DWIDTH-1:0] data;
  } wb_req_t;

  wb_req_t          exu_req, lsu_req, win_req;
  logic             exu_gnt, lsu_gnt, gnt, wr_fire;
  logic             last_grant;
  logic             alloc_fire, clr_hit;
  logic [NREG-1:0]  busy;

  assign exu_req = {exu_rd, exu_data};
  assign lsu_req = {lsu_rd, lsu_data};

  // Under contention the source that did not win last time goes first.
  assign exu_gnt = rst_n & exu_valid & (~lsu_valid | last_grant);
  assign lsu_gnt = rst_n & lsu_valid & (~exu_valid | ~last_grant);
  assign gnt     = exu_gnt | lsu_gnt;
  assign win_req = lsu_gnt ? lsu_req : exu_req;
  assign wr_fire = gnt & (|win_req.rd);

  assign exu_ready = exu_gnt;
  assign lsu_ready = lsu_gnt;

  // Re-allocating a pending register stalls issue until its write lands.
  assign alloc_ready = rst_n & ((alloc_rd == '0) | ~busy[alloc_rd]);
  assign alloc_fire  = alloc_valid & alloc_ready & (|alloc_rd);
  assign clr_hit     = rf_wen & busy[rf_waddr];

  assign busy1 = busy[raddr1];
  assign busy2 = busy[raddr2];

  for (genvar i = 0; i < NREG; i++) begin : g_sb
    if (i == 0) begin : g_x0
      assign busy[i] = 1'b0;
    end else begin : g_reg
      logic set_i, clr_i;
      assign set_i = alloc_fire & (alloc_rd == AWIDTH'(i));
      assign clr_i = rf_wen & (rf_waddr == AWIDTH'(i));
      rf_wb_sb_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (set_i),
        .clr   (clr_i),
        .busy  (busy[i])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pend_cnt   <= '0;
      wb_err     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rf_wen <= wr_fire;
      if (gnt) begin
        rf_waddr   <= win_req.rd;
        rf_wdata   <= win_req.data;
        last_grant <= lsu_gnt;
        if (wr_fire && !busy[win_req.rd]) wb_err <= 1'b1;
      end
      // Set and clear never target the same index, so they cancel exactly.
      case ({alloc_fire, clr_hit})
        2'b10:   pend_cnt <= pend_cnt + (AWIDTH+1)'(1);
        2'b01:   pend_cnt <= pend_cnt - (AWIDTH+1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: scenario tasks with inline checks; RF writes are
// matched against an expected-write queue by a negedge monitor.

module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_valid, alloc_ready;
  logic [AW-1:0] alloc_rd, raddr1, raddr2;
  logic          busy1, busy2;
  logic          exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] exu_rd, lsu_rd;
  logic [DW-1:0] exu_data, lsu_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW:0]   pend_cnt;
  logic          wb_err;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt), .wb_err(wb_err)
  );

  function automatic wr_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
          n_err++;
          $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alloc_valid = 0; alloc_rd = '0; raddr1 = '0; raddr2 = '0;
    exu_valid = 0; exu_rd = '0; exu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic test_reset;
    idle;
    rst_n = 0; alloc_valid = 1; exu_valid = 1; lsu_valid = 1;
    tick; tick; #1;
    n_cmp++; if ({alloc_ready, exu_ready, lsu_ready} !== 3'b000) begin n_err++;
      $display("FAIL reset_ready: got %b, required 000", {alloc_ready, exu_ready, lsu_ready}); end
    n_cmp++; if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pend_cnt !== '0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL reset_state: got wen=%b waddr=%0d wdata=%h pend=%0d err=%b, required all zero",
               rf_wen, rf_waddr, rf_wdata, pend_cnt, wb_err); end
    idle; rst_n = 1;
    tick;
  endtask

  task automatic test_basic;
    alloc_valid = 1; alloc_rd = 5; raddr1 = 5; #1;
    n_cmp++; if (alloc_ready !== 1'b1 || busy1 !== 1'b0 || pend_cnt !== 6'd0) begin n_err++;
      $display("FAIL basic_alloc: got rdy=%b busy=%b pend=%0d, required 1 0 0", alloc_ready, busy1, pend_cnt); end
    tick; alloc_valid = 0; #1;
    n_cmp++; if (busy1 !== 1'b1 || pend_cnt !== 6'd1) begin n_err++;
      $display("FAIL basic_pending: got busy=%b pend=%0d, required 1 1", busy1, pend_cnt); end
    tick; exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF; #1;
    n_cmp++; if (exu_ready !== 1'b1 || busy1 !== 1'b1) begin n_err++;
      $display("FAIL basic_grant: got rdy=%b busy=%b, required 1 1", exu_ready, busy1); end
    exp_q.push_back(mk(5, 32'hDEADBEEF));
    tick; exu_valid = 0; #1;
    n_cmp++; if (rf_wen !== 1'b1 || busy1 !== 1'b1 || pend_cnt !== 6'd1) begin n_err++;
      $display("FAIL basic_write_cycle: got wen=%b busy=%b pend=%0d, required 1 1 1", rf_wen, busy1, pend_cnt); end
    tick; #1;
    n_cmp++; if (rf_wen !== 1'b0 || busy1 !== 1'b0 || pend_cnt !== 6'd0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL basic_cleared: got wen=%b busy=%b pend=%0d err=%b, required 0 0 0 0", rf_wen, busy1, pend_cnt, wb_err); end
    idle;
  endtask

  task automatic test_contention;
    rst_n = 0; tick; rst_n = 1;
    alloc_valid = 1; alloc_rd = 3; tick;
    alloc_rd = 7; tick;
    alloc_rd = 8; tick;
    alloc_valid = 0; #1;
    n_cmp++; if (pend_cnt !== 6'd3) begin n_err++;
      $display("FAIL cont_pend3: got %0d, required 3", pend_cnt); end
    exu_valid = 1; exu_rd = 3; exu_data = 32'hA0A0_0003;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hB0B0_0007; #1;
    n_cmp++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_err++;
      $display("FAIL cont_first_exu: got exu=%b lsu=%b, required 1 0", exu_ready, lsu_ready); end
    exp_q.push_back(mk(3, 32'hA0A0_0003));
    // EXU presents a fresh request while LSU holds: LSU must win now.
    tick; exu_rd = 8; exu_data = 32'hC0C0_0008; #1;
    n_cmp++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b1 || rf_wen !== 1'b1) begin n_err++;
      $display("FAIL cont_second_lsu: got exu=%b lsu=%b wen=%b, required 0 1 1", exu_ready, lsu_ready, rf_wen); end
    exp_q.push_back(mk(7, 32'hB0B0_0007));
    tick; lsu_valid = 0; #1;
    n_cmp++; if (exu_ready !== 1'b1 || rf_wen !== 1'b1) begin n_err++;
      $display("FAIL cont_third_exu: got exu=%b wen=%b, required 1 1", exu_ready, rf_wen); end
    exp_q.push_back(mk(8, 32'hC0C0_0008));
    tick; exu_valid = 0; #1;
    n_cmp++; if (rf_wen !== 1'b1) begin n_err++;
      $display("FAIL cont_third_write: got wen=%b, required 1", rf_wen); end
    tick; #1;
    n_cmp++; if (rf_wen !== 1'b0 || pend_cnt !== 6'd0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL cont_drained: got wen=%b pend=%0d err=%b, required 0 0 0", rf_wen, pend_cnt, wb_err); end
    idle;
  endtask

  task automatic test_alternate;
    logic exp_lsu;
    int   n_exu, n_lsu;
    exp_lsu = 1'b1;  // EXU won the last grant
    n_exu = 0; n_lsu = 0;
    exu_valid = 1; lsu_valid = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (exu_ready !== ~exp_lsu || lsu_ready !== exp_lsu) begin n_err++;
        $display("FAIL alt_cycle%0d: got exu=%b lsu=%b, required %b %b", i, exu_ready, lsu_ready, ~exp_lsu, exp_lsu); end
      if (exu_ready === 1'b1) n_exu++;
      if (lsu_ready === 1'b1) n_lsu++;
      exp_lsu = ~exp_lsu;
      tick;
    end
    idle; #1;
    n_cmp++; if (n_exu != 3 || n_lsu != 3 || rf_wen !== 1'b0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL alt_fairness: got exu=%0d lsu=%0d wen=%b err=%b, required 3 3 0 0", n_exu, n_lsu, rf_wen, wb_err); end
  endtask

  task automatic test_waw;
    alloc_valid = 1; alloc_rd = 4; raddr1 = 4; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++;
      $display("FAIL waw_first: got %b, required 1", alloc_ready); end
    tick; #1;
    n_cmp++; if (alloc_ready !== 1'b0 || pend_cnt !== 6'd1) begin n_err++;
      $display("FAIL waw_stall: got rdy=%b pend=%0d, required 0 1", alloc_ready, pend_cnt); end
    tick; alloc_rd = 0; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++;
      $display("FAIL waw_x0_ready: got %b, required 1", alloc_ready); end
    tick; alloc_rd = 4; exu_valid = 1; exu_rd = 4; exu_data = 32'h0000_0044; #1;
    n_cmp++; if (pend_cnt !== 6'd1 || alloc_ready !== 1'b0 || exu_ready !== 1'b1) begin n_err++;
      $display("FAIL waw_grant: got pend=%0d rdy=%b exu=%b, required 1 0 1", pend_cnt, alloc_ready, exu_ready); end
    exp_q.push_back(mk(4, 32'h0000_0044));
    tick; exu_valid = 0; #1;
    n_cmp++; if (alloc_ready !== 1'b0 || rf_wen !== 1'b1) begin n_err++;
      $display("FAIL waw_write_cycle: got rdy=%b wen=%b, required 0 1", alloc_ready, rf_wen); end
    tick; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++;
      $display("FAIL waw_release: got %b, required 1", alloc_ready); end
    tick; alloc_valid = 0; #1;
    n_cmp++; if (pend_cnt !== 6'd1 || busy1 !== 1'b1) begin n_err++;
      $display("FAIL waw_realloc: got pend=%0d busy=%b, required 1 1", pend_cnt, busy1); end
    exu_valid = 1; exu_data = 32'h0000_0045;
    exp_q.push_back(mk(4, 32'h0000_0045));
    tick; exu_valid = 0; tick; #1;
    n_cmp++; if (pend_cnt !== 6'd0 || busy1 !== 1'b0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL waw_final: got pend=%0d busy=%b err=%b, required 0 0 0", pend_cnt, busy1, wb_err); end
    idle;
  endtask

  task automatic test_rd0_err;
    exu_valid = 1; exu_rd = 0; exu_data = 32'h0000_1234; #1;
    n_cmp++; if (exu_ready !== 1'b1) begin n_err++;
      $display("FAIL rd0_ready: got %b, required 1", exu_ready); end
    tick; exu_valid = 0; #1;
    n_cmp++; if (rf_wen !== 1'b0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL rd0_nowrite: got wen=%b err=%b, required 0 0", rf_wen, wb_err); end
    exu_valid = 1; exu_rd = 9; exu_data = 32'h0000_0099; #1;
    exp_q.push_back(mk(9, 32'h0000_0099));
    tick; exu_valid = 0; #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || wb_err !== 1'b1 || pend_cnt !== 6'd0) begin n_err++;
      $display("FAIL err_set: got wen=%b addr=%0d err=%b pend=%0d, required 1 9 1 0", rf_wen, rf_waddr, wb_err, pend_cnt); end
    repeat (3) tick;
    #1;
    n_cmp++; if (wb_err !== 1'b1) begin n_err++;
      $display("FAIL err_sticky: got %b, required 1", wb_err); end
    idle;
  endtask

  task automatic test_reset_mid;
    alloc_valid = 1; alloc_rd = 2; raddr2 = 2; tick;
    alloc_valid = 0;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h0000_2222; #1;
    n_cmp++; if (lsu_ready !== 1'b1 || busy2 !== 1'b1) begin n_err++;
      $display("FAIL rmid_grant: got lsu=%b busy=%b, required 1 1", lsu_ready, busy2); end
    exp_q.push_back(mk(2, 32'h0000_2222));
    tick;
    rst_n = 0; exu_valid = 1; alloc_valid = 1; alloc_rd = 6; #1;
    n_cmp++; if ({alloc_ready, exu_ready, lsu_ready} !== 3'b000) begin n_err++;
      $display("FAIL rmid_ready: got %b, required 000", {alloc_ready, exu_ready, lsu_ready}); end
    tick; idle; raddr2 = 2; #1;
    n_cmp++; if (rf_wen !== 1'b0 || busy2 !== 1'b0 || pend_cnt !== 6'd0 || wb_err !== 1'b0) begin n_err++;
      $display("FAIL rmid_state: got wen=%b busy=%b pend=%0d err=%b, required 0 0 0 0", rf_wen, busy2, pend_cnt, wb_err); end
    rst_n = 1;
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_contention;
    test_alternate;
    test_waw;
    test_rd0_err;
    test_reset_mid;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++;
      $display("FAIL wr_queue_drain: got %0d pending writes, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: EXU (ALU/CSR results) and LSU (load data).
- Arbitrates the two sources round-robin and registers the winning write one cycle before it reaches the RF.
- Keeps a per-register pending scoreboard: issue allocates a destination, the RF write clears it; decode uses it for RAW/WAW interlock.
- Sits between issue/EXU/LSU and the register file (x0 hardwired zero, combinational read, write on posedge).

Parameters:
- AWIDTH, 5, register address width; 2**AWIDTH registers.
- DWIDTH, 32, data width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- alloc_valid  in  1  issue wants to mark alloc_rd pending.
- alloc_rd  in  AWIDTH  destination register being issued.
- alloc_ready  out  1  allocation accepted this cycle.
- raddr1, raddr2  in  AWIDTH  decode source registers to check.
- busy1, busy2  out  1  source register has a pending write.
- exu_valid, lsu_valid  in  1  writeback request.
- exu_rd, lsu_rd  in  AWIDTH  writeback destination.
- exu_data, lsu_data  in  DWIDTH  writeback data.
- exu_ready, lsu_ready  out  1  request granted this cycle.
- rf_wen  out  1  RF write enable.
- rf_waddr  out  AWIDTH  RF write address.
- rf_wdata  out  DWIDTH  RF write data.
- pend_cnt  out  AWIDTH+1  number of set scoreboard bits.
- wb_err  out  1  sticky: a writeback targeted a nonzero register that was not pending.

Behaviour:
- State: busy[2**AWIDTH-1:0], last_grant (0=EXU, 1=LSU), output register {rf_wen, rf_waddr, rf_wdata}, pend_cnt, wb_err.
- Reset (rst_n=0 at posedge): all busy bits=0; rf_wen=0; rf_waddr=0; rf_wdata=0; pend_cnt=0; wb_err=0; last_grant=1 (EXU wins first contention).
- While rst_n=0: alloc_ready, exu_ready and lsu_ready are forced 0.
- Reset mid-operation discards any registered write: rf_wen=0 in the following cycle.

Arbitration (combinational ready):
- Only one source valid: it is granted.
- Both valid: the source not equal to last_grant is granted; the other sees ready=0 and must hold valid, rd and data stable.
- Neither valid: no grant.
- Ready never depends on the other source's rd. The output register always accepts, so no other backpressure exists.
- last_grant updates to the winner on every grant.

Write path (latency 1):
- On a grant in cycle N: cycle N+1 has rf_wen=1, rf_waddr=rd, rf_wdata=data. Otherwise rf_wen=0 in N+1.
- rd=0: the handshake completes, rf_wen stays 0, and no scoreboard effect occurs.

Scoreboard:
- busy is cleared at the edge ending cycle N+1, when rf_wen=1 for that address. This is the same edge at which the RF stores the data, so busy=0 implies the RF read returns new data.
- busyX = busy[raddrX] from registered state only; raddrX=0 gives busyX=0.
- alloc_ready = alloc_valid-independent: (alloc_rd==0) | ~busy[alloc_rd]. Allocating a pending rd stalls issue (WAW).
- Alloc handshake with alloc_rd≠0 sets busy[alloc_rd] at that edge.
- Set and clear of the same index in one edge cannot occur, because alloc_ready=0 while busy. Set and clear of different indices in one edge are both applied.
- pend_cnt = popcount-equivalent counter: +1 on set, −1 on clear, unchanged when both or neither occur. It never exceeds 2**AWIDTH−1.
- wb_err is set at a grant whose rd≠0 and busy[rd]=0. It stays set until reset.

Test Plan:
- Reset, then alloc rd=5, EXU writeback rd=5 data=0xDEADBEEF → busy1 (raddr1=5)=1 for 2+ cycles; rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after grant; busy1=0 after that edge; pend_cnt 0→1→0.
- Alloc rd=3 and rd=7; EXU and LSU valid in the same cycle for 3 and 7 → EXU granted first, LSU one cycle later (ready=0 then 1), two consecutive rf_wen pulses. Repeat contention → LSU wins first.
- Both sources continuously valid for 6 cycles → grants strictly alternate; no source starved.
- Alloc rd=4 pending, second alloc rd=4 → alloc_ready=0 until the cycle after rd=4's RF write edge. Alloc rd=0 → alloc_ready=1 and pend_cnt unchanged.
- Writeback rd=0 → exu_ready=1, rf_wen stays 0, wb_err=0. Writeback rd=9 never allocated → rf_wen=1, wb_err=1 and sticky.
- Alloc rd=2, grant LSU rd=2, assert rst_n=0 in the next cycle → rf_wen=0, busy all 0, pend_cnt=0, all readies 0 during reset.
